jesd_tx_link_ctrl: RTL and testbench

Link-layer sequencer for the 8-lane transmit path: it runs the local multiframe counter and steps the link through idle, code-group sync (CGS), initial lane alignment (ILAS) and user data, driven by the receiver's sync request. It sits beside the per-lane 8b/10b link encoders. It supplies the control octet (K flag plus value) broadcast to all lanes, and the select that switches the lanes onto framed ADC/test data. It also counts receiver error-report pulses.

---
 rtl/jesd_tx_link_ctrl.sv | 154 +++++++++++++++
 tb/tb_jesd_tx_link_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jesd_tx_link_ctrl.sv
// jesd_tx_link_ctrl
//   Link-layer sequencer for the 8-lane JESD transmit path. It runs the local
//   multiframe counter (LMFC) and steps the link through IDLE -> CGS -> ILAS -> DATA
//   under control of the receiver's sync_n request. It supplies the control octet
//   broadcast to every lane encoder, and the select that moves the lanes onto
//   framed data. It also counts short sync_n error-report pulses seen in DATA.
//
// Ports
//   clk, rst       single clock, async active-high reset
//   link_en        low forces IDLE
//   sync_n         receiver sync request (active-low, already in clk domain)
//   cfg_data       14 ILAS configuration octets, octet n = cfg_data[8n+7:8n]
//   state          0=IDLE 1=CGS 2=ILAS 3=DATA
//   tx_k/tx_octet  control character for all lanes
//   data_sel       lanes carry frame data
//   lmfc_cnt       octet index in multiframe, lmfc_pulse at index 0
//   link_up        state==DATA
//   err_cnt        saturating count of short sync_n pulses in DATA
module jesd_tx_link_ctrl #(
  parameter int K            = 32,
  parameter int ILAS_MF      = 4,
  parameter int SYNC_LOW_MIN = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         link_en,
  input  logic         sync_n,
  input  logic [111:0] cfg_data,
  output logic [1:0]   state,
  output logic         tx_k,
  output logic [7:0]   tx_octet,
  output logic         data_sel,
  output logic [7:0]   lmfc_cnt,
  output logic         lmfc_pulse,
  output logic         link_up,
  output logic [7:0]   err_cnt
);

  localparam int MW = (ILAS_MF > 1) ? $clog2(ILAS_MF) : 1;
  localparam int SW = $clog2(SYNC_LOW_MIN + 1);

  localparam logic [7:0]    LMFC_LAST = 8'(K - 1);
  localparam logic [MW-1:0] M_LAST    = MW'(ILAS_MF - 1);
  localparam logic [MW-1:0] M_CFG     = MW'(1);
  localparam logic [SW-1:0] SLC_LAST  = SW'(SYNC_LOW_MIN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CGS  = 2'd1,
    ST_ILAS = 2'd2,
    ST_DATA = 2'd3
  } st_t;

  st_t           st;
  logic [MW-1:0] mf;         // ILAS multiframe index
  logic [SW-1:0] slc;        // consecutive sync_n-low cycles in DATA
  logic          sync_seen;  // sync_n was high on the previous CGS cycle

  wire lmfc_last = (lmfc_cnt == LMFC_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= ST_IDLE;
      lmfc_cnt  <= 8'd0;
      mf        <= '0;
      slc       <= '0;
      sync_seen <= 1'b0;
      err_cnt   <= 8'd0;
    end else begin
      // LMFC free-runs regardless of link state
      lmfc_cnt <= lmfc_last ? 8'd0 : lmfc_cnt + 8'd1;
      if (st != ST_DATA) slc <= '0;

      if (!link_en) begin
        st <= ST_IDLE;
      end else begin
        case (st)
          ST_IDLE: st <= ST_CGS;
          ST_CGS: begin
            sync_seen <= sync_n;
            // requiring sync_seen means a rise exactly on the last octet
            // waits for the following boundary
            if (lmfc_last && sync_n && sync_seen) begin
              st <= ST_ILAS;
              mf <= '0;
            end
          end
          ST_ILAS: begin
            if (!sync_n) begin
              st <= ST_CGS;
            end else if (lmfc_last) begin
              mf <= mf + 1'b1;
              if (mf == M_LAST) st <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (!sync_n) begin
              if (slc == SLC_LAST) begin
                st        <= ST_CGS;
                sync_seen <= 1'b0;
                slc       <= '0;
              end else begin
                slc <= slc + 1'b1;
              end
            end else begin
              // a low pulse too short to be a resync request is an error report
              if (slc != '0 && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
              slc <= '0;
            end
          end
          default: st <= ST_IDLE;
        endcase
      end
    end
  end

  logic [3:0] cfg_idx;
  assign cfg_idx = lmfc_cnt[3:0] - 4'd2;

  always_comb begin
    tx_k     = 1'b0;
    tx_octet = 8'h00;
    data_sel = 1'b0;
    case (st)
      ST_CGS: begin
        tx_k     = 1'b1;
        tx_octet = 8'hBC;
      end
      ST_ILAS: begin
        if (lmfc_cnt == 8'd0) begin
          tx_k     = 1'b1;
          tx_octet = 8'h1C;
        end else if (lmfc_last) begin
          tx_k     = 1'b1;
          tx_octet = 8'h7C;
        end else if (mf == M_CFG && lmfc_cnt == 8'd1) begin
          tx_k     = 1'b1;
          tx_octet = 8'h9C;
        end else if (mf == M_CFG && lmfc_cnt >= 8'd2 && lmfc_cnt <= 8'd15) begin
          tx_octet = cfg_data[{cfg_idx, 3'b000} +: 8];
        end else begin
          tx_octet = lmfc_cnt;
        end
      end
      ST_DATA: data_sel = 1'b1;
      default: ;
    endcase
  end

  assign state      = st;
  assign lmfc_pulse = (lmfc_cnt == 8'd0);
  assign link_up    = (st == ST_DATA);

endmodule

// File: tb/tb_jesd_tx_link_ctrl.sv
// Testbench for jesd_tx_link_ctrl. Each driven cycle pushes the expected
// post-edge outputs onto a scoreboard queue; a negedge monitor pops and compares.
module tb_jesd_tx_link_ctrl;

  localparam int K   = 32;
  localparam int IMF = 4;
  localparam int SLM = 5;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CGS  = 2'd1;
  localparam logic [1:0] S_ILAS = 2'd2;
  localparam logic [1:0] S_DATA = 2'd3;

  logic         clk = 1'b0;
  logic         rst;
  logic         link_en;
  logic         sync_n;
  logic [111:0] cfg_data;
  logic [1:0]   state;
  logic         tx_k;
  logic [7:0]   tx_octet;
  logic         data_sel;
  logic [7:0]   lmfc_cnt;
  logic         lmfc_pulse;
  logic         link_up;
  logic [7:0]   err_cnt;

  jesd_tx_link_ctrl #(.K(K), .ILAS_MF(IMF), .SYNC_LOW_MIN(SLM)) dut (
    .clk(clk), .rst(rst), .link_en(link_en), .sync_n(sync_n), .cfg_data(cfg_data),
    .state(state), .tx_k(tx_k), .tx_octet(tx_octet), .data_sel(data_sel),
    .lmfc_cnt(lmfc_cnt), .lmfc_pulse(lmfc_pulse), .link_up(link_up), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] st;
    logic       k;
    logic [7:0] oct;
    logic [7:0] lm;
    logic [7:0] err;
  } exp_t;

  typedef struct {
    logic       en;
    logic       sn;
    logic [1:0] st;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[6];

  int vecs = 0;
  int bad  = 0;
  int cyc  = 0;
  int lm;          // bench's own LMFC position
  int ip;          // octet position within the ILAS
  logic [1:0] prev_st;
  logic [7:0] exp_err;

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", nm, cyc, got, exp);
    end
  endtask

  function automatic void ilas_exp(input int m, input int j,
                                   output logic k, output logic [7:0] o);
    k = 1'b0;
    o = 8'(j);
    if (j == 0) begin
      k = 1'b1; o = 8'h1C;
    end else if (j == K - 1) begin
      k = 1'b1; o = 8'h7C;
    end else if (m == 1 && j == 1) begin
      k = 1'b1; o = 8'h9C;
    end else if (m == 1 && j >= 2 && j <= 15) begin
      o = cfg_data[8*(j-2) +: 8];
    end
  endfunction

  // Drive one cycle; st is the state expected after the edge.
  task automatic tick(input logic en, input logic sn, input logic [1:0] st);
    exp_t e;
    link_en = en;
    sync_n  = sn;
    @(posedge clk);
    lm = (lm + 1) % K;
    if (st == S_ILAS) ip = (prev_st == S_ILAS) ? ip + 1 : 0;
    prev_st = st;
    e.st  = st;
    e.lm  = 8'(lm);
    e.err = exp_err;
    e.k   = 1'b0;
    e.oct = 8'h00;
    if (st == S_CGS) begin
      e.k = 1'b1; e.oct = 8'hBC;
    end else if (st == S_ILAS) begin
      ilas_exp(ip / K, lm, e.k, e.oct);
    end
    sb.push_back(e);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      cyc++;
      cmp("state",      state,      e.st);
      cmp("link_up",    link_up,    e.st == S_DATA);
      cmp("data_sel",   data_sel,   e.st == S_DATA);
      cmp("tx_k",       tx_k,       e.k);
      cmp("tx_octet",   tx_octet,   e.oct);
      cmp("lmfc_cnt",   lmfc_cnt,   e.lm);
      cmp("lmfc_pulse", lmfc_pulse, e.lm == 8'd0);
      cmp("err_cnt",    err_cnt,    e.err);
    end
  end

  // sync_n held high in CGS until ILAS; sync_seen must be clear, or the first
  // cycle must not be the last octet of a multiframe.
  task automatic run_to_ilas();
    bit first = 1'b1;
    bit done  = 1'b0;
    while (!done) begin
      done = (lm == K - 1) && !first;
      tick(1'b1, 1'b1, done ? S_ILAS : S_CGS);
      first = 1'b0;
    end
  endtask

  // From the first ILAS octet: the rest of the ILAS, then DATA.
  task automatic run_ilas();
    for (int t = 1; t <= IMF * K; t++)
      tick(1'b1, 1'b1, (t == IMF * K) ? S_DATA : S_ILAS);
  endtask

  task automatic resync();
    repeat (SLM - 1) tick(1'b1, 1'b0, S_DATA);
    tick(1'b1, 1'b0, S_CGS);
  endtask

  task automatic reset_checks(input string tag);
    cmp({tag, "_state"},  state,      S_IDLE);
    cmp({tag, "_k"},      tx_k,       1'b0);
    cmp({tag, "_oct"},    tx_octet,   8'h00);
    cmp({tag, "_dsel"},   data_sel,   1'b0);
    cmp({tag, "_lmfc"},   lmfc_cnt,   8'd0);
    cmp({tag, "_pulse"},  lmfc_pulse, 1'b1);
    cmp({tag, "_linkup"}, link_up,    1'b0);
    cmp({tag, "_err"},    err_cnt,    8'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    link_en  = 1'b0;
    sync_n   = 1'b0;
    cfg_data = 112'h0D0C0B0A09080706050403020100;
    lm = 0; ip = 0; exp_err = 8'd0; prev_st = S_IDLE;

    #3 reset_checks("reset");
    #9 rst = 1'b0;

    // disabled: IDLE, LMFC keeps running (pulse every K cycles)
    repeat (40) tick(1'b0, 1'b0, S_IDLE);

    // enable/disable vectors
    tbl[0] = '{1'b0, 1'b1, S_IDLE};
    tbl[1] = '{1'b1, 1'b0, S_CGS};
    tbl[2] = '{1'b0, 1'b0, S_IDLE};
    tbl[3] = '{1'b1, 1'b0, S_CGS};
    tbl[4] = '{1'b1, 1'b0, S_CGS};
    tbl[5] = '{1'b1, 1'b0, S_CGS};
    foreach (tbl[i]) tick(tbl[i].en, tbl[i].sn, tbl[i].st);

    // sync_n rises at lmfc 10: 21 more CGS cycles, ILAS at lmfc 0
    while (lm != 10) tick(1'b1, 1'b0, S_CGS);
    run_to_ilas();
    run_ilas();

    // short low pulse in DATA: error report, link stays up
    repeat (3) tick(1'b1, 1'b0, S_DATA);
    exp_err = 8'd1;
    tick(1'b1, 1'b1, S_DATA);

    // SLM consecutive lows: resync
    resync();
    run_to_ilas();
    run_ilas();

    // err_cnt saturation
    for (int i = 0; i < 300; i++) begin
      tick(1'b1, 1'b0, S_DATA);
      if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
      tick(1'b1, 1'b1, S_DATA);
    end

    // ILAS abort at mf2 j7, restart with m=0
    resync();
    run_to_ilas();
    repeat (2 * K + 7) tick(1'b1, 1'b1, S_ILAS);
    tick(1'b1, 1'b0, S_CGS);
    run_to_ilas();
    run_ilas();

    // link_en drop in DATA: IDLE, err_cnt kept
    tick(1'b0, 1'b1, S_IDLE);
    tick(1'b1, 1'b0, S_CGS);

    // CGS glitch: high at 20, low from 25 -> boundary passes without ILAS
    while (lm != 20) tick(1'b1, 1'b0, S_CGS);
    repeat (5) tick(1'b1, 1'b1, S_CGS);
    repeat (8) tick(1'b1, 1'b0, S_CGS);

    // link_en drop mid-ILAS
    run_to_ilas();
    repeat (40) tick(1'b1, 1'b1, S_ILAS);
    tick(1'b0, 1'b1, S_IDLE);
    tick(1'b0, 1'b1, S_IDLE);

    @(negedge clk);
    #1 cmp("sb_drain", sb.size(), 0);

    // asynchronous reset clears everything including err_cnt
    rst = 1'b1;
    #1 reset_checks("async_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
    $finish;
  end

endmodule
